// File: rtl/imm_encoder.sv
`default_nettype none
// imm_encoder: packs a signed immediate, register indices and a format code into an
// RV64 LD/SD/BEQ word behind a one-deep valid/ready output stage. Rev 1.0
module imm_encoder #(
  parameter int N     = 64,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       fmt,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [N-1:0]     imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N/2-1:0]   out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int IW = N / 2;
  localparam logic [IW-1:0] C_NOP = IW'(32'h0000_0013);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_instr;
  logic            r_err;
  logic [CNT_W-1:0] r_enc;
  logic [ERR_W-1:0] r_errc;

  logic            w_accept;
  logic            w_drain;
  logic            w_fits12;
  logic            w_fits13;
  logic            w_bad;
  logic [IW-1:0]   w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = (r_state == S_EMPTY) | out_ready;
    case (r_state)
      S_EMPTY: if (in_valid)               w_next = S_FULL;
      S_FULL:  if (out_ready && !in_valid) w_next = S_EMPTY;
      default:                             w_next = S_EMPTY;
    endcase
  end

  assign w_accept  = in_valid & in_ready;
  assign w_drain   = (r_state == S_FULL) & out_ready;
  assign out_valid = (r_state == S_FULL);

  // In range means every bit above the field's sign bit copies that sign bit.
  assign w_fits12 = (imm[N-1:11] == '0) | (imm[N-1:11] == '1);
  assign w_fits13 = (imm[N-1:12] == '0) | (imm[N-1:12] == '1);

  always_comb begin
    w_bad  = 1'b0;
    w_word = C_NOP;
    case (fmt)
      2'b00: begin
        w_bad  = !w_fits12;
        w_word = IW'({imm[11:0], rs1, 3'b011, rd, 7'b0000011});
      end
      2'b01: begin
        w_bad  = !w_fits12;
        w_word = IW'({imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011});
      end
      2'b10: begin
        w_bad  = !w_fits13 | imm[0];
        w_word = IW'({imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011});
      end
      default: begin
        w_bad  = 1'b1;
        w_word = C_NOP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_bad ? C_NOP : w_word;
      r_err   <= w_bad;
    end
  end

  // Statistics follow what the consumer actually takes, not what was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc  <= '0;
      r_errc <= '0;
    end else if (w_drain) begin
      r_enc <= r_enc + CNT_W'(1);
      if (r_err && (r_errc != '1)) r_errc <= r_errc + ERR_W'(1);
    end
  end

  assign out_instr = r_instr;
  assign out_err   = r_err;
  assign enc_count = r_enc;
  assign err_count = r_errc;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// Bench for imm_encoder: directed vectors, literal checks and a queue-based reference model.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = 2'b00;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [63:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_w[$];
  logic        q_e[$];
  int          m_enc = 0;
  int          m_err = 0;

  always #5 clk = ~clk;

  imm_encoder #(.N(64), .CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoding written as field arithmetic on the numeric immediate.
  function automatic void model(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [63:0] im,
                                output logic [31:0] w, output logic e);
    longint      s;
    int unsigned u;
    bit          ok;
    s  = $signed(im);
    u  = im[31:0];
    ok = 1'b0;
    w  = 32'h13;
    case (f)
      2'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((u & 32'hFFF) << 20) + (32'(s1) << 15) + (32'd3 << 12) + (32'(d) << 7) + 32'd3;
      end
      2'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) + (32'(s2) << 20) + (32'(s1) << 15) + (32'd3 << 12)
           + ((u & 32'h1F) << 7) + 32'h23;
      end
      2'd2: begin
        ok = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
        w  = (((u >> 12) & 32'h1) << 31) + (((u >> 5) & 32'h3F) << 25) + (32'(s2) << 20)
           + (32'(s1) << 15) + (((u >> 1) & 32'hF) << 8) + (((u >> 11) & 32'h1) << 7) + 32'h63;
      end
      default: ok = 1'b0;
    endcase
    e = !ok;
    if (!ok) w = 32'h13;
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    logic        e;
    bit          acc, drn;
    if (!rst_n) begin
      q_w.delete();
      q_e.delete();
      m_enc = 0;
      m_err = 0;
    end else begin
      chk("out_valid", out_valid, q_w.size() != 0);
      if (q_w.size() != 0) begin
        chk("out_instr", out_instr, q_w[0]);
        chk("out_err", out_err, q_e[0]);
      end
      chk("enc_count", enc_count, m_enc);
      chk("err_count", err_count, m_err);
      chk("in_ready", in_ready, (q_w.size() == 0) || out_ready);
      drn = (q_w.size() != 0) && out_ready;
      acc = in_valid && ((q_w.size() == 0) || out_ready);
      if (drn) begin
        m_enc = (m_enc + 1) % 65536;
        if (q_e[0] && m_err < 255) m_err++;
        void'(q_w.pop_front());
        void'(q_e.pop_front());
      end
      if (acc) begin
        model(fmt, rd, rs1, rs2, imm, w, e);
        q_w.push_back(w);
        q_e.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [63:0] im);
    int n;
    fmt = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_w, input logic exp_e);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk(name, out_instr, exp_w);
    chk({name, "_err"}, out_err, exp_e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_enc", enc_count, 16'd0);
    chk("rst_errc", err_count, 8'd0);
    rst_n = 1'b1;
    idle();

    send(2'd0, 5'd5, 5'd2, 5'd17, 64'd8);      lit("ld8", 32'h00813283, 1'b0); idle();
    chk("enc_after_ld", enc_count, 16'd1);
    send(2'd1, 5'd7, 5'd2, 5'd5, -64'sd16);    lit("sd_m16", 32'hFE513823, 1'b0); idle();
    send(2'd2, 5'd9, 5'd1, 5'd2, -64'sd4);     lit("beq_m4", 32'hFE208EE3, 1'b0); idle();
    send(2'd0, 5'd1, 5'd0, 5'd31, 64'd2047);   lit("ld_2047", 32'h7FF03083, 1'b0); idle();
    send(2'd0, 5'd1, 5'd0, 5'd0, 64'd2048);    lit("ld_2048", 32'h00000013, 1'b1); idle();
    chk("errc_after_2048", err_count, 8'd1);
    send(2'd2, 5'd0, 5'd0, 5'd0, 64'd4094);    lit("beq_4094", 32'h7E000FE3, 1'b0); idle();
    send(2'd2, 5'd0, 5'd0, 5'd0, 64'd6);       lit("beq_6", 32'h00000363, 1'b0); idle();
    send(2'd2, 5'd0, 5'd0, 5'd0, 64'd3);       lit("beq_3", 32'h00000013, 1'b1); idle();
    send(2'd3, 5'd1, 5'd1, 5'd1, 64'd0);       lit("fmt3", 32'h00000013, 1'b1); idle();
    send(2'd0, 5'd1, 5'd1, 5'd1, 64'h0000_0001_0000_0000); lit("ld_hi", 32'h00000013, 1'b1); idle();
    send(2'd0, 5'd3, 5'd3, 5'd3, -64'sd2048);  idle();
    send(2'd0, 5'd3, 5'd3, 5'd3, -64'sd2049);  idle();
    send(2'd1, 5'd3, 5'd4, 5'd6, 64'd2047);    idle();
    send(2'd2, 5'd3, 5'd4, 5'd6, -64'sd4096);  idle();
    send(2'd2, 5'd3, 5'd4, 5'd6, 64'd4096);    idle();

    // Backpressure: hold for three cycles, then drain and refill on the same edge.
    out_ready = 1'b0;
    send(2'd0, 5'd3, 5'd4, 5'd0, 64'd16);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_instr", out_instr, 32'h01023183);
      chk("bp_hold_ready", in_ready, 1'b0);
      chk("bp_hold_valid", out_valid, 1'b1);
      idle();
    end
    fmt = 2'd1; rd = 5'd0; rs1 = 5'd1; rs2 = 5'd2; imm = 64'd8;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lit("bp_next", 32'h0020B423, 1'b0);
    idle();

    // Asynchronous reset while a word is stalled.
    out_ready = 1'b0;
    send(2'd0, 5'd5, 5'd2, 5'd0, 64'd8);
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_instr", out_instr, 32'h0);
    chk("arst_enc", enc_count, 16'd0);
    chk("arst_errc", err_count, 8'd0);
    idle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'd2, 5'd0, 5'd1, 5'd2, -64'sd4);     lit("post_rst", 32'hFE208EE3, 1'b0); idle();
    chk("post_rst_enc", enc_count, 16'd1);

    // Saturation of the error counter.
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    fmt = 2'd3; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle();
    chk("sat_errc", err_count, 8'hFF);
    chk("sat_enc", enc_count, 16'd300);

    repeat (3) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
